// File: rtl/mixcolumn_seq_if.sv
// rtl/mixcolumn_seq_if.sv - handshake bundle between the round datapath and the sequential MixColumns stage
interface mixcolumn_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, mode, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, mode, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/mixcolumn_seq.sv
// rtl/mixcolumn_seq.sv - sequential AES MixColumns / InvMixColumns, LANES columns per cycle
module mixcolumn_seq #(
  parameter int LANES  = 1,
  parameter bit INV_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mixcolumn_seq_if.slave bus
);

  localparam int NGRP  = 4 / LANES;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("mixcolumn_seq: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     work_q;
  logic [127:0]     work_d;
  logic             mode_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             inv_sel;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient used (01,02,03,09,0b,0d,0e) fits in 4 bits, so a
  // multiply is an XOR of up to three xtime() doublings.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [3:0] k0, k1, k2, k3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    k0 = inv ? 4'he : 4'h2;
    k1 = inv ? 4'hb : 4'h3;
    k2 = inv ? 4'hd : 4'h1;
    k3 = inv ? 4'h9 : 4'h1;
    b0 = gmul(a0, k0) ^ gmul(a1, k1) ^ gmul(a2, k2) ^ gmul(a3, k3);
    b1 = gmul(a0, k3) ^ gmul(a1, k0) ^ gmul(a2, k1) ^ gmul(a3, k2);
    b2 = gmul(a0, k2) ^ gmul(a1, k3) ^ gmul(a2, k0) ^ gmul(a3, k1);
    b3 = gmul(a0, k1) ^ gmul(a1, k2) ^ gmul(a2, k3) ^ gmul(a3, k0);
    return {b0, b1, b2, b3};
  endfunction

  // With INV_EN=0 this folds to constant 0 and the inverse terms vanish.
  assign inv_sel = INV_EN && mode_q;

  always_comb begin
    int col;
    col    = 0;
    work_d = work_q;
    for (int l = 0; l < LANES; l++) begin
      col = (int'(cnt_q) * LANES + l) & 3;
      work_d[127 - 32*col -: 32] = mix_col(work_q[127 - 32*col -: 32], inv_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.data_in;
            mode_q     <= INV_EN ? bus.mode : 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = work_q;

endmodule
